mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Memory-side responder for the CPU's single-port memory bus. It takes the CPU's address, write data, write strobe and error, and returns read data.
- Holds a word-addressed RAM, zeroes it after reset, then accepts a program image through a loader port starting at the entry point.
- Releases the CPU to run once loading completes.
- Also provides one memory-mapped I/O word and halts the bus when the CPU flags an error.

Parameters:
- RAM_WORDS, 1024, RAM depth in 16-bit words; power of two.
- ENTRY_POINT, 16'h0020, first load address; the CPU starts fetching here.
- IO_ADDR, 16'h0010, full 16-bit address of the I/O word.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- cpu_addr  in  16  CPU bus address
- cpu_wdata  in  16  CPU write data
- cpu_we  in  1  CPU write strobe; sampled on the clk rising edge
- cpu_error  in  1  CPU error flag
- cpu_rdata  out  16  registered read data
- ready  out  1  high only in RUN; CPU must not fetch while low
- load_valid  in  1  loader word valid
- load_data  in  16  loader word
- load_done  in  1  end of image
- load_ready  out  1  high only in LOAD
- io_in  in  16  external input word
- io_out  out  16  external output register
- io_strobe  out  1  one-cycle pulse on each I/O write
- halted  out  1  high in HALT

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n low at a rising edge).
- Reset values: state=CLEAR, clear_ptr=0, cpu_rdata=0, ready=0, load_ready=0, io_out=0, io_strobe=0, halted=0.
- Reset mid-operation: from any state, return to CLEAR and re-clear the whole RAM.
- RAM index: idx = cpu_addr[log2(RAM_WORDS)-1:0]. Upper address bits are ignored, so addresses alias; 16'hFFFF maps to word RAM_WORDS-1.
- States:
  - CLEAR: each cycle write 0 to ram[clear_ptr], then clear_ptr++. After writing word RAM_WORDS-1, go to LOAD with load_ptr = ENTRY_POINT mod RAM_WORDS. Clearing takes exactly RAM_WORDS cycles. All CPU and loader inputs are ignored.
  - LOAD: load_ready=1.
    - On load_valid: ram[load_ptr] <= load_data, then load_ptr++ modulo RAM_WORDS (wrap-around allowed).
    - On load_done: go to RUN next cycle. If load_valid and load_done are high in the same cycle, the word is written, then RUN.
    - CPU inputs are ignored.
  - RUN: ready=1.
    - Read: cpu_rdata is registered one cycle after cpu_addr is presented. It returns io_in if cpu_addr==IO_ADDR, otherwise ram[idx]. Reads happen every cycle regardless of cpu_we.
    - Read and write to the same address in one cycle: cpu_rdata returns the old data (read-first).
    - Write with cpu_addr==IO_ADDR: io_out <= cpu_wdata, io_strobe=1 for the next cycle only. RAM is not written.
    - Other writes: ram[idx] <= cpu_wdata.
    - cpu_error=1: go to HALT next cycle. Any write in that same cycle is suppressed, including an I/O write.
  - HALT: ready=0, halted=1. All writes are ignored. Reads are still served with RUN timing so memory can be inspected. Only reset leaves HALT.
- Ignored inputs: loader inputs outside LOAD; cpu_error outside RUN.
- io_strobe: back-to-back I/O writes keep it high on consecutive cycles. io_out holds its last value.

Test Plan:
- Reset, then release rst_n -> ready=0 and load_ready=0 for exactly 1024 cycles; load_ready=1 on the next cycle.
- Load 0x000A, 0x000B, 0x000C with load_done asserted alongside the third word -> ready=1 next cycle.
  - Reading 0x0020 gives 0x000A on the following cycle; 0x0022 gives 0x000C.
  - 0x0100 reads 0x0000, proving the clear.
- In RUN, write 0x1234 to 0xFFFF -> reading 0xFFFF returns 0x1234, and reading 0x03FF also returns 0x1234 (alias).
  - Write 0x5678 to 0x0040 while reading 0x0040 in the same cycle -> old value 0x0000 is returned; the next read gives 0x5678.
- Write 0x00AB to 0x0010 -> io_out=0x00AB and io_strobe high exactly one cycle.
  - A RAM read of 0x0410 (aliases word 0x10) returns 0x0000.
  - With io_in=0x5555, reading 0x0010 returns 0x5555.
- cpu_error=1 together with a write of 0x7777 to 0x0050 -> halted=1 and ready=0 next cycle.
  - Reading 0x0050 returns 0x0000.
  - A later write to 0x0060 is ignored.
- Pull rst_n low for one cycle mid-LOAD after two words -> state CLEAR.
  - After 1024 cycles, LOAD restarts at 0x0020.
  - Previously loaded words read 0x0000 once in RUN.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Memory-side responder for a single-port CPU bus: word RAM with clear/load
// bring-up, one memory-mapped I/O word, and a halt-on-error bus state.
module mem_bus_responder #(
   parameter int          RAM_WORDS   = 1024,
   parameter logic [15:0] ENTRY_POINT = 16'h0020,
   parameter logic [15:0] IO_ADDR     = 16'h0010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   input  logic        cpu_we,
   input  logic        cpu_error,
   output logic [15:0] cpu_rdata,
   output logic        ready,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   input  logic        load_done,
   output logic        load_ready,
   input  logic [15:0] io_in,
   output logic [15:0] io_out,
   output logic        io_strobe,
   output logic        halted
);

   localparam int AW = $clog2(RAM_WORDS);
   localparam logic [AW-1:0] ENTRY_IDX = ENTRY_POINT[AW-1:0];
   localparam logic [AW-1:0] LAST_IDX  = AW'(RAM_WORDS - 1);

   typedef enum logic [1:0] {CLEAR, LOAD, RUN, HALT} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] clear_ptr, load_ptr, idx;
   logic [15:0]   ram [RAM_WORDS];
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [15:0]   ram_wdata;
   logic          io_wr;
   logic          is_io;

   assign idx        = cpu_addr[AW-1:0];
   assign is_io      = (cpu_addr == IO_ADDR);
   assign ready      = (state == RUN);
   assign load_ready = (state == LOAD);
   assign halted     = (state == HALT);

   // One RAM write port shared by clear, loader and CPU, selected by state.
   always_comb begin
      state_nx  = state;
      ram_we    = 1'b0;
      ram_waddr = clear_ptr;
      ram_wdata = 16'h0000;
      io_wr     = 1'b0;
      case (state)
         CLEAR: begin
            ram_we = 1'b1;
            if (clear_ptr == LAST_IDX) state_nx = LOAD;
         end
         LOAD: begin
            if (load_valid) begin
               ram_we    = 1'b1;
               ram_waddr = load_ptr;
               ram_wdata = load_data;
            end
            if (load_done) state_nx = RUN;
         end
         RUN: begin
            if (cpu_error) begin
               state_nx = HALT;
            end else if (cpu_we) begin
               if (is_io) begin
                  io_wr = 1'b1;
               end else begin
                  ram_we    = 1'b1;
                  ram_waddr = idx;
                  ram_wdata = cpu_wdata;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= CLEAR;
         clear_ptr <= '0;
         load_ptr  <= ENTRY_IDX;
      end else begin
         state <= state_nx;
         if (state == CLEAR) begin
            clear_ptr <= clear_ptr + 1'b1;
            load_ptr  <= ENTRY_IDX;
         end else if (state == LOAD && load_valid) begin
            load_ptr <= load_ptr + 1'b1;
         end
      end
   end

   // RAM has no reset; the CLEAR sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (rst_n && ram_we) ram[ram_waddr] <= ram_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cpu_rdata <= 16'h0000;
         io_out    <= 16'h0000;
         io_strobe <= 1'b0;
      end else begin
         io_strobe <= io_wr;
         if (io_wr) io_out <= cpu_wdata;
         if (state == RUN || state == HALT)
            cpu_rdata <= is_io ? io_in : ram[idx];
      end
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: read results are queued as they are
// requested and compared when the registered data appears.
module tb_mem_bus_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cpu_addr, cpu_wdata, load_data, io_in;
   logic        cpu_we, cpu_error, load_valid, load_done;
   logic [15:0] cpu_rdata, io_out;
   logic        ready, load_ready, io_strobe, halted;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q [$];

   always #5 clk = ~clk;

   mem_bus_responder dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
      .cpu_error(cpu_error), .cpu_rdata(cpu_rdata), .ready(ready),
      .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
      .load_ready(load_ready), .io_in(io_in), .io_out(io_out),
      .io_strobe(io_strobe), .halted(halted)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] e);
      cpu_addr = a;
      cpu_we   = 1'b0;
      exp_q.push_back(e);
      tick();
      chk($sformatf("rd_%h", a), {16'h0, cpu_rdata}, {16'h0, exp_q.pop_front()});
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_we    = 1'b1;
      tick();
      cpu_we = 1'b0;
   endtask

   // Counts samples with load_ready low, starting from the current one.
   task automatic wait_load(input string tag);
      int n = 0;
      int rdy_seen = 0;
      while (!load_ready && n < 2000) begin
         if (ready) rdy_seen++;
         n++;
         tick();
      end
      chk({tag, "_clear_cycles"}, n, 1024);
      chk({tag, "_ready_in_clear"}, rdy_seen, 0);
   endtask

   task automatic load_word(input logic [15:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_done  = last;
      tick();
      load_valid = 1'b0;
      load_done  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_error = 1'b0;
      load_valid = 1'b0; load_data = '0; load_done = 1'b0; io_in = '0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_ready", ready, 0);
      chk("rst_load_ready", load_ready, 0);
      chk("rst_halted", halted, 0);
      chk("rst_io_out", io_out, 0);
      chk("rst_io_strobe", io_strobe, 0);
      chk("rst_rdata", cpu_rdata, 0);

      wait_load("boot");
      load_word(16'h000A, 1'b0);
      load_word(16'h000B, 1'b0);
      load_word(16'h000C, 1'b1);
      chk("run_ready", ready, 1);
      chk("run_load_ready", load_ready, 0);
      rd(16'h0020, 16'h000A);
      rd(16'h0021, 16'h000B);
      rd(16'h0022, 16'h000C);
      rd(16'h0100, 16'h0000);

      wr(16'hFFFF, 16'h1234);
      rd(16'hFFFF, 16'h1234);
      rd(16'h03FF, 16'h1234);

      // Same-cycle read and write returns the old word.
      cpu_addr = 16'h0040; cpu_wdata = 16'h5678; cpu_we = 1'b1;
      exp_q.push_back(16'h0000);
      tick();
      cpu_we = 1'b0;
      chk("read_first", cpu_rdata, exp_q.pop_front());
      rd(16'h0040, 16'h5678);

      wr(16'h0010, 16'h00AB);
      chk("io_out", io_out, 16'h00AB);
      chk("io_strobe_hi", io_strobe, 1);
      rd(16'h0410, 16'h0000);
      chk("io_strobe_lo", io_strobe, 0);
      io_in = 16'h5555;
      rd(16'h0010, 16'h5555);

      wr(16'h0010, 16'h0001);
      chk("b2b_strobe1", io_strobe, 1);
      wr(16'h0010, 16'h0002);
      chk("b2b_strobe2", io_strobe, 1);
      chk("b2b_io_out", io_out, 16'h0002);
      tick();
      chk("b2b_strobe_end", io_strobe, 0);

      cpu_addr = 16'h0050; cpu_wdata = 16'h7777; cpu_we = 1'b1; cpu_error = 1'b1;
      tick();
      cpu_we = 1'b0; cpu_error = 1'b0;
      chk("halt_halted", halted, 1);
      chk("halt_ready", ready, 0);
      rd(16'h0050, 16'h0000);
      wr(16'h0060, 16'h9999);
      rd(16'h0060, 16'h0000);
      wr(16'h0010, 16'h00EE);
      chk("halt_io_strobe", io_strobe, 0);
      chk("halt_io_out", io_out, 16'h0002);
      chk("halt_sticky", halted, 1);

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_load("rst2");
      load_word(16'h0011, 1'b0);
      load_word(16'h0022, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midload_clear", load_ready, 0);
      wait_load("rst3");
      load_word(16'h0033, 1'b1);
      chk("rst3_run", ready, 1);
      rd(16'h0020, 16'h0033);
      rd(16'h0021, 16'h0000);
      rd(16'h0040, 16'h0000);
      rd(16'hFFFF, 16'h0000);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
